// File: rtl/sqrt_arbiter_if.sv
// Requester and core-side signal bundle for the shared square-root arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface sqrt_arbiter_if #(
    parameter int NREQ = 4,
    parameter int N    = 32
);
    // Requester operand channel
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_num;
    logic [NREQ-1:0]   req_ready;

    // Requester response channel
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [N/2-1:0]    rsp_res;
    logic              rsp_err;

    // Square-root core channel
    logic [N-1:0]      core_num;
    logic              core_valid;
    logic [N/2-1:0]    core_res;
    logic              core_ready;
    logic              core_reset_n;

    modport slave (
        input  req_valid,
        input  req_num,
        output req_ready,
        output rsp_valid,
        input  rsp_ready,
        output rsp_res,
        output rsp_err,
        output core_num,
        output core_valid,
        input  core_res,
        input  core_ready,
        output core_reset_n
    );

    modport master (
        output req_valid,
        output req_num,
        input  req_ready,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_res,
        input  rsp_err,
        input  core_num,
        input  core_valid,
        output core_res,
        output core_ready,
        input  core_reset_n
    );
endinterface

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter that shares one sequential square-root core among NREQ
// requesters, with a watchdog that aborts and resets a core that never finishes.
module sqrt_arbiter #(
    parameter int NREQ    = 4,
    parameter int N       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    sqrt_arbiter_if.slave bus_if
);
    localparam int IDXW = $clog2(NREQ);
    localparam int RW   = N / 2;
    localparam int WDW  = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ABORT,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] last_grant_q, last_grant_d;
    logic [IDXW-1:0] grant_q, grant_d;
    logic [N-1:0]    core_num_q, core_num_d;
    logic [RW-1:0]   rsp_res_q, rsp_res_d;
    logic            rsp_err_q, rsp_err_d;
    logic [WDW-1:0]  wdog_q, wdog_d;

    logic [NREQ-1:0] req_ready;
    logic [NREQ-1:0] rsp_valid;
    logic            core_valid;

    logic [N-1:0]    req_ops [NREQ];
    logic            found;
    logic [IDXW-1:0] pick;
    logic [IDXW:0]   cand;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_ops[i] = bus_if.req_num[i*N +: N];
        end
    end

    // Scan starts one past the previous winner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = {1'b0, last_grant_q} + (IDXW+1)'(i);
            if (cand >= (IDXW+1)'(NREQ)) begin
                cand = cand - (IDXW+1)'(NREQ);
            end
            if (!found && bus_if.req_valid[cand[IDXW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDXW-1:0];
            end
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        core_num_d   = core_num_q;
        rsp_res_d    = rsp_res_q;
        rsp_err_d    = rsp_err_q;
        wdog_d       = wdog_q;
        req_ready    = '0;
        rsp_valid    = '0;
        core_valid   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (found && reset) begin
                    req_ready[pick] = 1'b1;
                    core_num_d      = req_ops[pick];
                    grant_d         = pick;
                    last_grant_d    = pick;
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                core_valid = 1'b1;
                wdog_d     = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (bus_if.core_ready) begin
                    rsp_res_d = bus_if.core_res;
                    rsp_err_d = 1'b0;
                    state_d   = RESP;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                    if (wdog_d == WDW'(TIMEOUT - 1)) begin
                        state_d = ABORT;
                    end
                end
            end
            ABORT: begin
                rsp_res_d = '0;
                rsp_err_d = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                rsp_valid[grant_q] = 1'b1;
                if (bus_if.rsp_ready[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and active-low, so it is tested inside the
        // clocked branch rather than in the sensitivity list.
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= IDXW'(NREQ - 1);
            grant_q      <= '0;
            core_num_q   <= '0;
            rsp_res_q    <= '0;
            rsp_err_q    <= 1'b0;
            wdog_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from
            // the same pre-edge values, independent of statement order.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            core_num_q   <= core_num_d;
            rsp_res_q    <= rsp_res_d;
            rsp_err_q    <= rsp_err_d;
            wdog_q       <= wdog_d;
        end
    end

    assign bus_if.req_ready    = req_ready;
    assign bus_if.rsp_valid    = rsp_valid;
    assign bus_if.rsp_res      = rsp_res_q;
    assign bus_if.rsp_err      = rsp_err_q;
    assign bus_if.core_num     = core_num_q;
    assign bus_if.core_valid   = core_valid;
    // Core is held in reset with the block and for the single abort cycle.
    assign bus_if.core_reset_n = reset & (state_q != ABORT);
endmodule

// File: tb/tb_sqrt_arbiter.sv
// Scoreboard bench for sqrt_arbiter: directed requests feed expected grants and
// responses into queues that an independent monitor pops on each handshake.
module tb_sqrt_arbiter;
    localparam int NREQ    = 4;
    localparam int N       = 32;
    localparam int TIMEOUT = 64;
    localparam int RW      = N / 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sqrt_arbiter_if #(.NREQ(NREQ), .N(N)) bus ();

    sqrt_arbiter #(.NREQ(NREQ), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus)
    );

    typedef struct {
        int            idx;
        logic [RW-1:0] res;
        logic          err;
    } rsp_t;

    rsp_t exp_rsp[$];
    int   exp_grant[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   core_lat = 3;
    bit   honour   = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [RW-1:0] isqrt(input logic [N-1:0] x);
        logic [RW-1:0] r;
        logic [RW-1:0] t;
        r = '0;
        for (int b = RW - 1; b >= 0; b--) begin
            t = r | (RW'(1) << b);
            if (64'(t) * 64'(t) <= 64'(x)) r = t;
        end
        return r;
    endfunction

    function automatic rsp_t mk(input int idx, input logic [RW-1:0] res, input logic err);
        rsp_t e;
        e.idx = idx;
        e.res = res;
        e.err = err;
        return e;
    endfunction

    // Starts at a sample point; ends at the sample point where rsp_valid == mask.
    task automatic wait_rsp(input string name, input logic [NREQ-1:0] mask, input int budget);
        int n;
        n = 0;
        smp();
        while (bus.rsp_valid !== mask && n < budget) begin
            drv();
            smp();
            n++;
        end
        check(name, 64'(bus.rsp_valid), 64'(mask));
    endtask

    // Starts and ends at a drive point; drops each req_valid once accepted.
    task automatic drain(input string name, input int budget);
        logic [NREQ-1:0] acc;
        int n;
        n = 0;
        while ((bus.req_valid != '0 || exp_rsp.size() != 0) && n < budget) begin
            smp();
            acc = bus.req_ready;
            drv();
            bus.req_valid = bus.req_valid & ~acc;
            n++;
        end
        check(name, 64'(exp_rsp.size()), 64'd0);
    endtask

    // Behavioural core: answers L cycles after the start pulse.
    initial begin
        int            cnt;
        logic [N-1:0]  num;
        cnt             = 0;
        num             = '0;
        bus.core_ready  = 1'b0;
        bus.core_res    = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.core_ready = 1'b0;
            if (honour && !bus.core_reset_n) begin
                cnt = 0;
            end else if (bus.core_valid) begin
                cnt = core_lat;
                num = bus.core_num;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.core_ready = 1'b1;
                    bus.core_res   = isqrt(num);
                end
            end
        end
    end

    // Monitor: grants and completed responses against the scoreboard queues.
    initial begin
        rsp_t            e;
        int              g;
        logic [NREQ-1:0] oh;
        forever begin
            smp();
            if (bus.req_ready != '0) begin
                if (exp_grant.size() == 0) begin
                    check("unexpected_grant", 64'(bus.req_ready), 64'd0);
                end else begin
                    g      = exp_grant.pop_front();
                    oh     = '0;
                    oh[g]  = 1'b1;
                    check("grant", 64'(bus.req_ready), 64'(oh));
                end
            end
            if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
                if (exp_rsp.size() == 0) begin
                    check("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
                end else begin
                    e     = exp_rsp.pop_front();
                    oh    = '0;
                    oh[e.idx] = 1'b1;
                    check("rsp_valid", 64'(bus.rsp_valid), 64'(oh));
                    check("rsp_res", 64'(bus.rsp_res), 64'(e.res));
                    check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: run still active at %0t, expected completion", $time);
        $fatal(1, "bench did not complete");
    end

    initial begin
        reset         = 1'b0;
        bus.req_valid = '0;
        bus.req_num   = '0;
        bus.rsp_ready = '0;

        // Reset values
        repeat (3) drv();
        smp();
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_res", 64'(bus.rsp_res), 64'd0);
        check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("rst_core_num", 64'(bus.core_num), 64'd0);
        check("rst_core_valid", 64'(bus.core_valid), 64'd0);
        check("rst_core_reset_n", 64'(bus.core_reset_n), 64'd0);
        drv();
        reset = 1'b1;

        // Rotation: all valid, grants 0,1,2,3
        for (int i = 0; i < NREQ; i++) exp_grant.push_back(i);
        exp_rsp.push_back(mk(0, 16'd0, 1'b0));
        exp_rsp.push_back(mk(1, 16'd1, 1'b0));
        exp_rsp.push_back(mk(2, 16'd65535, 1'b0));
        exp_rsp.push_back(mk(3, 16'd1000, 1'b0));
        bus.rsp_ready = '1;
        bus.req_num   = {32'd1000000, 32'hFFFF_FFFF, 32'd1, 32'd0};
        bus.req_valid = '1;
        drain("rotation_drain", 300);

        // Single request with cycle-level timing, L = 3
        core_lat = 3;
        exp_grant.push_back(2);
        exp_rsp.push_back(mk(2, 16'd12, 1'b0));
        bus.req_num[2*N +: N] = 32'd144;
        bus.req_valid = 4'b0100;
        smp();
        check("single_req_ready_t", 64'(bus.req_ready), 64'h4);
        drv();
        bus.req_valid = '0;
        smp();
        check("single_core_valid_t1", 64'(bus.core_valid), 64'd1);
        check("single_core_num", 64'(bus.core_num), 64'd144);
        check("single_req_ready_t1", 64'(bus.req_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            drv();
            smp();
            check("single_rsp_early", 64'(bus.rsp_valid), 64'd0);
            check("single_core_valid_low", 64'(bus.core_valid), 64'd0);
        end
        drv();
        smp();
        check("single_rsp_valid_t5", 64'(bus.rsp_valid), 64'h4);
        drv();
        smp();
        check("single_rsp_drop", 64'(bus.rsp_valid), 64'd0);
        drv();

        // Backpressure on requester 1 with requester 0 waiting
        bus.rsp_ready = '0;
        exp_grant.push_back(1);
        exp_rsp.push_back(mk(1, 16'd7, 1'b0));
        bus.req_num[1*N +: N] = 32'd49;
        bus.req_valid = 4'b0010;
        smp();
        check("bp_accept", 64'(bus.req_ready), 64'h2);
        drv();
        bus.req_num[0*N +: N] = 32'd16;
        bus.req_valid = 4'b0001;
        wait_rsp("bp_wait_rsp", 4'b0010, 40);
        for (int k = 0; k < 10; k++) begin
            drv();
            smp();
            check("bp_rsp_valid_held", 64'(bus.rsp_valid), 64'h2);
            check("bp_rsp_res_held", 64'(bus.rsp_res), 64'd7);
            check("bp_no_accept", 64'(bus.req_ready), 64'd0);
        end
        exp_grant.push_back(0);
        exp_rsp.push_back(mk(0, 16'd4, 1'b0));
        drv();
        bus.rsp_ready = 4'b0010;
        smp();
        check("bp_no_accept_u", 64'(bus.req_ready), 64'd0);
        drv();
        bus.rsp_ready = '1;
        smp();
        check("b2b_accept_u1", 64'(bus.req_ready), 64'h1);
        drv();
        bus.req_valid = '0;
        drain("bp_drain", 50);

        // Watchdog abort with a late core pulse
        honour   = 1'b0;
        core_lat = TIMEOUT + 3;
        bus.rsp_ready = '0;
        exp_grant.push_back(3);
        exp_rsp.push_back(mk(3, 16'd0, 1'b1));
        bus.req_num[3*N +: N] = 32'd25;
        bus.req_valid = 4'b1000;
        smp();
        check("to_accept", 64'(bus.req_ready), 64'h8);
        drv();
        bus.req_valid = '0;
        smp();
        check("to_issue", 64'(bus.core_valid), 64'd1);
        for (int k = 1; k <= TIMEOUT; k++) begin
            drv();
            smp();
            check("to_core_reset_n", 64'(bus.core_reset_n), (k == TIMEOUT) ? 64'd0 : 64'd1);
        end
        for (int k = 0; k < 5; k++) begin
            drv();
            smp();
            check("to_rsp_valid", 64'(bus.rsp_valid), 64'h8);
            check("to_rsp_err", 64'(bus.rsp_err), 64'd1);
            check("to_rsp_res", 64'(bus.rsp_res), 64'd0);
            check("to_core_reset_n_high", 64'(bus.core_reset_n), 64'd1);
        end
        drv();
        bus.rsp_ready = '1;
        honour   = 1'b1;
        core_lat = 3;
        drain("to_drain", 50);

        // Stray rsp_ready on another requester is ignored
        bus.rsp_ready = 4'b1000;
        exp_grant.push_back(1);
        exp_rsp.push_back(mk(1, 16'd9, 1'b0));
        bus.req_num[1*N +: N] = 32'd81;
        bus.req_valid = 4'b0010;
        smp();
        check("stray_accept", 64'(bus.req_ready), 64'h2);
        drv();
        bus.req_valid = '0;
        wait_rsp("stray_wait_rsp", 4'b0010, 40);
        for (int k = 0; k < 5; k++) begin
            drv();
            smp();
            check("stray_rsp_pending", 64'(bus.rsp_valid), 64'h2);
            check("stray_rsp_res", 64'(bus.rsp_res), 64'd9);
        end
        drv();
        bus.rsp_ready = 4'b0010;
        drain("stray_drain", 20);
        bus.rsp_ready = '1;

        // Reset in the middle of WAIT
        core_lat = 10;
        exp_grant.push_back(2);
        bus.req_num[2*N +: N] = 32'd9;
        bus.req_valid = 4'b0100;
        smp();
        drv();
        bus.req_valid = '0;
        smp();
        drv();
        smp();
        drv();
        reset = 1'b0;
        smp();
        check("mid_core_reset_n_follows", 64'(bus.core_reset_n), 64'd0);
        drv();
        smp();
        check("mid_req_ready", 64'(bus.req_ready), 64'd0);
        check("mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("mid_rsp_res", 64'(bus.rsp_res), 64'd0);
        check("mid_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("mid_core_num", 64'(bus.core_num), 64'd0);
        check("mid_core_valid", 64'(bus.core_valid), 64'd0);
        drv();
        reset    = 1'b1;
        core_lat = 3;
        exp_grant.push_back(0);
        exp_rsp.push_back(mk(0, 16'd16, 1'b0));
        bus.req_num[0*N +: N] = 32'd256;
        bus.req_valid = 4'b0001;
        smp();
        check("post_reset_accept", 64'(bus.req_ready), 64'h1);
        drv();
        bus.req_valid = '0;
        drain("post_reset_drain", 50);

        check("grants_outstanding", 64'(exp_grant.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
